hilo_div_unit: RTL

HI/LO register stage directly downstream of the ALU. It captures the ALU's 64-bit multiply result {hi,lo}, services MTHI/MTLO writes, and performs iterative 32-bit signed/unsigned division into HI/LO. It presents a busy stall to the pipeline control and a one-cycle done pulse when a division result lands.

---
 rtl/hilo_div_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: HI/LO register stage with ALU product capture, MTHI/MTLO writes
// and a WIDTH-cycle restoring signed/unsigned divider.
module hilo_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] alu_hi,
   input  logic [WIDTH-1:0] alu_lo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d, a_q, a_d;
   logic             negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, done_q, done_d;
   logic             sgn, sa, sb;
   logic [WIDTH:0]   rem_sh, diff;
   assign sgn    = ~op[0];
   assign sa     = sgn & a[WIDTH-1];
   assign sb     = sgn & b[WIDTH-1];
   // Restoring step: shift the next dividend bit into the remainder and trial-subtract.
   assign rem_sh = {rem_q, quot_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvsr_q};
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      dvsr_d  = dvsr_q;
      a_d     = a_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (op_valid) begin
            case (op)
               3'b001: begin
                  hi_d = alu_hi;
                  lo_d = alu_lo;
               end
               3'b010: hi_d = a;
               3'b011: lo_d = a;
               3'b100, 3'b101: begin
                  quot_d  = sa ? -a : a;
                  dvsr_d  = sb ? -b : b;
                  rem_d   = '0;
                  a_d     = a;
                  negq_d  = sa ^ sb;
                  negr_d  = sa;
                  dz_d    = (b == '0);
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = DIV;
               end
               default: ;
            endcase
         end
         DIV: begin
            rem_d   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quot_d  = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? FIN : DIV;
         end
         FIN: begin
            lo_d    = dz_q ? '1 : (negq_q ? -quot_q : quot_q);
            hi_d    = dz_q ? a_q : (negr_q ? -rem_q : rem_q);
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         dvsr_q  <= '0;
         a_q     <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         dvsr_q  <= dvsr_d;
         a_q     <= a_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
      end
   end
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;
endmodule
